ex_mdu: RTL and testbench

EX_MDU -- requirements
Module: ex_mdu

---
 rtl/ex_mdu_pkg.sv | 50 +++++
 rtl/ex_mdu_iter.sv | 31 +++
 rtl/ex_mdu.sv | 147 ++++++++++++++
 tb/tb_ex_mdu.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/ex_mdu_pkg.sv
// Shared execute-stage defines: base ALU op codes, MDU op codes and MDU FSM states.
// Small op-classification helpers keep the decode logic in one place.
package ex_mdu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLL = 3'd5,
    ALU_SRL = 3'd6,
    ALU_SRA = 3'd7
  } alu_op_e;

  typedef enum logic [2:0] {
    MDU_MUL    = 3'd0,
    MDU_MULH   = 3'd1,
    MDU_MULHSU = 3'd2,
    MDU_MULHU  = 3'd3,
    MDU_DIV    = 3'd4,
    MDU_DIVU   = 3'd5,
    MDU_REM    = 3'd6,
    MDU_REMU   = 3'd7
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } mdu_state_e;

  function automatic logic is_div_op(input mdu_op_e op);
    return op inside {MDU_DIV, MDU_DIVU, MDU_REM, MDU_REMU};
  endfunction

  function automatic logic is_rem_op(input mdu_op_e op);
    return op inside {MDU_REM, MDU_REMU};
  endfunction

  // Operand A is signed for MULHSU as well; operand B only for the fully signed ops.
  function automatic logic signed_a(input mdu_op_e op);
    return op inside {MDU_MUL, MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM};
  endfunction

  function automatic logic signed_b(input mdu_op_e op);
    return op inside {MDU_MUL, MDU_MULH, MDU_DIV, MDU_REM};
  endfunction

endpackage

// File: rtl/ex_mdu_iter.sv
// One radix-2 iteration of the MDU: shift-add for multiply, restoring
// shift-subtract for divide, on a 2*XLEN accumulator holding magnitudes.
module mdu_iter #(
  parameter int XLEN = 32
) (
  input  logic              is_div_i,
  input  logic [XLEN-1:0]   opnd_i,
  input  logic [2*XLEN-1:0] acc_i,
  output logic [2*XLEN-1:0] acc_o
);

  logic [XLEN:0] sum;
  logic [XLEN:0] trial;

  // NOTE: every signal written in always_comb gets a value on every path,
  // otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    acc_o = acc_i;
    // Multiply: {high half + (lsb ? multiplicand : 0)} then shift right, keeping the carry.
    sum   = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
    // Divide: trial-subtract the divisor from the partial remainder shifted left by one.
    trial = acc_i[2*XLEN-1:XLEN-1] - {1'b0, opnd_i};
    if (is_div_i) begin
      if (!trial[XLEN]) acc_o = {trial[XLEN-1:0], acc_i[XLEN-2:0], 1'b1};
      else              acc_o = {acc_i[2*XLEN-2:XLEN-1], acc_i[XLEN-2:0], 1'b0};
    end else begin
      acc_o = {sum, acc_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/ex_mdu.sv
// Iterative multiply/divide unit: IDLE -> CALC (XLEN steps) -> DONE, with
// sign fixup, divide-by-zero and signed-overflow short cuts.
module ex_mdu
  import ex_mdu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int WD_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [2:0]      aluop_i,
  input  logic [XLEN-1:0] reg1_i,
  input  logic [XLEN-1:0] reg2_i,
  input  logic [WD_W-1:0] wd_i,
  input  logic            flush_i,
  output logic            stallreq_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o,
  output logic [WD_W-1:0] wd_o
);

  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  MIN_NEG   = {1'b1, {(XLEN-1){1'b0}}};

  if (XLEN < 8 || (XLEN % 2) != 0) begin : g_bad_xlen
    $error("ex_mdu: XLEN must be even and >= 8");
  end

  mdu_state_e        state_q;
  mdu_op_e           op_q;
  logic [WD_W-1:0]   wd_q;
  logic [WD_W-1:0]   wd_out_q;
  logic              neg_q;
  logic [XLEN-1:0]   opnd_q;
  logic [2*XLEN-1:0] acc_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [XLEN-1:0]   result_q;
  logic              valid_q;

  mdu_op_e           op_in;
  logic              a_neg, b_neg, neg_d;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              div_zero, div_ovf;
  logic [XLEN-1:0]   special_res;
  logic [2*XLEN-1:0] acc_d;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quot, rem;
  logic [XLEN-1:0]   fin_res;

  assign op_in = mdu_op_e'(aluop_i);

  // Accept-time decode: magnitudes, result sign and the two short-cut cases.
  always_comb begin
    a_neg    = signed_a(op_in) & reg1_i[XLEN-1];
    b_neg    = signed_b(op_in) & reg2_i[XLEN-1];
    a_mag    = a_neg ? -reg1_i : reg1_i;
    b_mag    = b_neg ? -reg2_i : reg2_i;
    neg_d    = is_rem_op(op_in) ? a_neg : (a_neg ^ b_neg);
    div_zero = is_div_op(op_in) && (reg2_i == '0);
    div_ovf  = (op_in inside {MDU_DIV, MDU_REM}) && (reg1_i == MIN_NEG) && (reg2_i == '1);
    if (div_zero) special_res = is_rem_op(op_in) ? reg1_i : '1;
    else          special_res = is_rem_op(op_in) ? '0 : reg1_i;
  end

  mdu_iter #(.XLEN(XLEN)) u_iter (
    .is_div_i (is_div_op(op_q)),
    .opnd_i   (opnd_q),
    .acc_i    (acc_q),
    .acc_o    (acc_d)
  );

  // Final sign fixup, applied to the output of the last iteration.
  always_comb begin
    prod = neg_q ? -acc_d : acc_d;
    quot = neg_q ? -acc_d[XLEN-1:0] : acc_d[XLEN-1:0];
    rem  = neg_q ? -acc_d[2*XLEN-1:XLEN] : acc_d[2*XLEN-1:XLEN];
    case (op_q)
      MDU_MUL:                          fin_res = prod[XLEN-1:0];
      MDU_MULH, MDU_MULHSU, MDU_MULHU:  fin_res = prod[2*XLEN-1:XLEN];
      MDU_DIV, MDU_DIVU:                fin_res = quot;
      default:                          fin_res = rem;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and the block order does not matter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      op_q     <= MDU_MUL;
      wd_q     <= '0;
      wd_out_q <= '0;
      neg_q    <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (flush_i) begin
        state_q <= ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start_i) begin
              op_q   <= op_in;
              wd_q   <= wd_i;
              neg_q  <= neg_d;
              cnt_q  <= '0;
              opnd_q <= is_div_op(op_in) ? b_mag : a_mag;
              acc_q  <= {{XLEN{1'b0}}, (is_div_op(op_in) ? a_mag : b_mag)};
              if (div_zero || div_ovf) begin
                state_q  <= ST_DONE;
                valid_q  <= 1'b1;
                result_q <= special_res;
                wd_out_q <= wd_i;
              end else begin
                state_q <= ST_CALC;
              end
            end
          end
          ST_CALC: begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == LAST_ITER) begin
              state_q  <= ST_DONE;
              valid_q  <= 1'b1;
              result_q <= fin_res;
              wd_out_q <= wd_q;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign stallreq_o = rst && (((state_q == ST_IDLE) && start_i && !flush_i) ||
                              (state_q == ST_CALC));
  assign valid_o    = valid_q;
  assign result_o   = result_q;
  assign wd_o       = wd_out_q;

endmodule

// File: tb/tb_ex_mdu.sv
// Scoreboard bench for ex_mdu: directed vectors push expected results,
// a negedge monitor pops and compares whenever valid_o is seen.
module tb_ex_mdu;
  import ex_mdu_pkg::*;

  localparam int XLEN = 32;
  localparam int WD_W = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            start_i;
  logic [2:0]      aluop_i;
  logic [XLEN-1:0] reg1_i, reg2_i;
  logic [WD_W-1:0] wd_i;
  logic            flush_i;
  logic            stallreq_o, valid_o;
  logic [XLEN-1:0] result_o;
  logic [WD_W-1:0] wd_o;

  typedef struct {
    logic [XLEN-1:0] res;
    logic [WD_W-1:0] wd;
    int              edge_n;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   ecnt   = 0;
  int   checks = 0;
  int   errors = 0;

  ex_mdu #(.XLEN(XLEN), .WD_W(WD_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .aluop_i    (aluop_i),
    .reg1_i     (reg1_i),
    .reg2_i     (reg2_i),
    .wd_i       (wd_i),
    .flush_i    (flush_i),
    .stallreq_o (stallreq_o),
    .valid_o    (valid_o),
    .result_o   (result_o),
    .wd_o       (wd_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ecnt <= ecnt + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst && valid_o) begin
      if (sb.size() == 0) begin
        check("spurious_valid", 64'(valid_o), 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check("result", 64'(result_o), 64'(mon_e.res));
        check("wd", 64'(wd_o), 64'(mon_e.wd));
        check("latency_edge", 64'(ecnt), 64'(mon_e.edge_n));
      end
    end
  end

  task automatic start_op(input logic [2:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                          input logic [WD_W-1:0] wd, input logic [XLEN-1:0] exp_res,
                          input bit special, input bit track);
    @(negedge clk);
    aluop_i = op; reg1_i = a; reg2_i = b; wd_i = wd; start_i = 1'b1;
    #1 check("stall_accept", 64'(stallreq_o), 64'd1);
    @(posedge clk);
    #1;
    start_i = 1'b0;
    reg1_i  = $urandom;
    reg2_i  = $urandom;
    wd_i    = WD_W'($urandom);
    if (track) sb.push_back('{exp_res, wd, ecnt + (special ? 0 : XLEN)});
  endtask

  // Walks to the DONE cycle of the last tracked op, checking stallreq_o on the way.
  task automatic wait_done();
    int target;
    target = sb[$].edge_n;
    do begin
      @(negedge clk);
      #1 check("stall_track", 64'(stallreq_o), 64'(ecnt != target));
    end while (ecnt < target);
    check("sb_drained", 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  task automatic run(input logic [2:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                     input logic [WD_W-1:0] wd, input logic [XLEN-1:0] exp_res, input bit special);
    start_op(op, a, b, wd, exp_res, special, 1'b1);
    wait_done();
  endtask

  initial begin
    rst = 1'b0; start_i = 1'b0; flush_i = 1'b0;
    aluop_i = '0; reg1_i = '0; reg2_i = '0; wd_i = '0;
    #1;
    check("rst_valid", 64'(valid_o), 64'd0);
    check("rst_stall", 64'(stallreq_o), 64'd0);
    check("rst_result", 64'(result_o), 64'd0);
    check("rst_wd", 64'(wd_o), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    run(MDU_MUL,    32'd7,        32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 1'b0);
    run(MDU_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'hFFFF_FFFE, 1'b0);
    run(MDU_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'h0000_0000, 1'b0);
    run(MDU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 32'hFFFF_FFFF, 1'b0);
    run(MDU_MUL,    32'h1234_5678, 32'h0000_0010, 5'd9, 32'h2345_6780, 1'b0);
    run(MDU_MULH,   32'h8000_0000, 32'h8000_0000, 5'd10, 32'h4000_0000, 1'b0);
    run(MDU_DIV,    32'hFFFF_FFF9, 32'd2,         5'd11, 32'hFFFF_FFFD, 1'b0);
    run(MDU_REM,    32'hFFFF_FFF9, 32'd2,         5'd12, 32'hFFFF_FFFF, 1'b0);
    run(MDU_DIV,    32'd7,        32'hFFFF_FFFE, 5'd13, 32'hFFFF_FFFD, 1'b0);
    run(MDU_REM,    32'd7,        32'hFFFF_FFFE, 5'd14, 32'h0000_0001, 1'b0);
    run(MDU_DIVU,   32'hFFFF_FFFF, 32'd3,         5'd15, 32'h5555_5555, 1'b0);
    run(MDU_REMU,   32'hFFFF_FFFF, 32'd10,        5'd16, 32'h0000_0005, 1'b0);
    run(MDU_DIVU,   32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'h0000_0000, 1'b0);
    // Short-cut cases complete one cycle after acceptance.
    run(MDU_DIVU,   32'd7,        32'd0,         5'd18, 32'hFFFF_FFFF, 1'b1);
    run(MDU_REMU,   32'd7,        32'd0,         5'd19, 32'h0000_0007, 1'b1);
    run(MDU_DIV,    32'hFFFF_FFFB, 32'd0,         5'd20, 32'hFFFF_FFFF, 1'b1);
    run(MDU_REM,    32'hFFFF_FFFB, 32'd0,         5'd21, 32'hFFFF_FFFB, 1'b1);
    run(MDU_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd22, 32'h8000_0000, 1'b1);
    run(MDU_REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd23, 32'h0000_0000, 1'b1);

    // A start during DONE is ignored; result/wd hold until the next DONE.
    run(MDU_MUL, 32'd6, 32'd7, 5'd24, 32'd42, 1'b0);
    aluop_i = MDU_MUL; reg1_i = 32'd2; reg2_i = 32'd2; start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    @(negedge clk);
    #1;
    check("done_start_ignored_stall", 64'(stallreq_o), 64'd0);
    check("done_start_ignored_valid", 64'(valid_o), 64'd0);
    repeat (40) @(negedge clk);
    check("result_hold", 64'(result_o), 64'd42);
    check("wd_hold", 64'(wd_o), 64'd24);

    // Flush at CALC cycle 10: back to IDLE, no result.
    start_op(MDU_DIVU, 32'd1000, 32'd3, 5'd25, 32'd0, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    flush_i = 1'b1;
    @(posedge clk);
    #1 flush_i = 1'b0;
    @(negedge clk);
    #1;
    check("flush_stall", 64'(stallreq_o), 64'd0);
    check("flush_valid", 64'(valid_o), 64'd0);
    repeat (40) @(negedge clk);
    check("flush_result_hold", 64'(result_o), 64'd42);
    run(MDU_DIVU, 32'd100, 32'd7, 5'd26, 32'd14, 1'b0);

    // Reset mid-CALC clears outputs immediately; the next op behaves as from cold.
    start_op(MDU_MUL, 32'd9, 32'd9, 5'd27, 32'd0, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_valid", 64'(valid_o), 64'd0);
    check("midrst_stall", 64'(stallreq_o), 64'd0);
    check("midrst_result", 64'(result_o), 64'd0);
    check("midrst_wd", 64'(wd_o), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    run(MDU_MUL, 32'd3, 32'd5, 5'd28, 32'd15, 1'b0);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
